pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Supervises the PLL macro: drives its reset, waits for lock, qualifies lock stability, then releases the downstream system reset.
- Retries on lock timeout and declares failure after a bounded number of retries.
- Handles loss of lock at run time and accepts a software relock request.
- Sits beside the PLL wrapper, clocked from the PLL reference clock, which is always valid even while the PLL is unlocked.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (>=1)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before a retry (>=2)
STABLE_CYCLES, 256, consecutive synchronized-locked cycles required before release (>=1)
MAX_RETRIES, 3, retries after the initial attempt before FAIL (0..15)
CNT_W, 16, shared cycle counter width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1

Ports:
refclk  in  1  reference clock, sole clock of the block
rst  in  1  synchronous active-high reset
pll_locked  in  1  PLL lock indication, asynchronous to refclk
relock_req  in  1  single-cycle request to restart the PLL
pll_rst  out  1  reset to PLL macro, active-high
sys_rst  out  1  downstream system reset, active-high
ready  out  1  high only in RUN
fail  out  1  high only in FAIL
retry_cnt  out  4  retries consumed since last rst/relock_req, saturates at 15
state  out  3  encoded state: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4

Behaviour:
Interface: single clock refclk; reset rst is synchronous and active-high. All outputs are registered.
Synchronization:
- pll_locked passes through a 2-flop synchronizer to produce locked_s.
- Synchronizer flops reset to 0.
Reset values:
- state=PLL_RST, counter=0, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0.
PLL_RST:
- pll_rst=1, sys_rst=1.
- Counter counts 0..RST_CYCLES-1; at RST_CYCLES-1, go to WAIT_LOCK with counter=0.
- pll_rst is therefore high for exactly RST_CYCLES cycles after rst deasserts.
WAIT_LOCK:
- pll_rst=0, sys_rst=1.
- locked_s=1 -> STABLE, counter=0.
- Else, at counter==LOCK_TIMEOUT-1:
  - retry_cnt==MAX_RETRIES -> FAIL.
  - Otherwise retry_cnt+1 and go to PLL_RST with counter=0.
STABLE:
- sys_rst=1.
- locked_s=0 -> WAIT_LOCK, counter=0 (timeout restarts, no retry consumed).
- counter==STABLE_CYCLES-1 with locked_s=1 -> RUN.
RUN:
- sys_rst=0, ready=1.
- locked_s=0 -> sys_rst=1 and ready=0 on the next edge; next state per the optional feature.
- retry_cnt is held.
FAIL:
- pll_rst=1, sys_rst=1, fail=1.
- Exits only via relock_req or rst.
relock_req:
- Accepted in RUN and FAIL only; ignored in other states.
- Action: go to PLL_RST, counter=0, retry_cnt=0, fail=0.
- In RUN, relock_req takes precedence over simultaneous lock loss.
Timing:
- First pll_locked=1 at edge t (held stable) -> state=STABLE at t+3 -> state=RUN with sys_rst=0 at t+3+STABLE_CYCLES.
- A lock glitch shorter than 1 cycle may be missed; this is acceptable.
Counter:
- Single CNT_W counter, cleared on every state change.
- Never wraps, because every state exits at its terminal count.

Optional Feature:
PLL_SEQ_AUTO_RELOCK_EN
- Defined: lock loss in RUN -> PLL_RST (PLL re-reset); retry_cnt cleared to 0.
- Undefined: lock loss in RUN -> WAIT_LOCK without pulsing pll_rst; retry_cnt held. Timeout from WAIT_LOCK then follows normal retry rules.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Power-up: rst high 3 cycles, then low; pll_locked rises 10 cycles after rst release -> pll_rst high exactly 4 cycles; RUN, sys_rst=0 and ready=1 exactly 11 cycles after pll_locked rises; retry_cnt=0.
- Never lock: pll_locked=0 -> 3 PLL reset pulses total (initial + 2 retries); retry_cnt steps 1,2; FAIL entered 32 cycles after third WAIT_LOCK entry; fail=1, pll_rst=1.
- Unstable lock: pll_locked toggles high 5 cycles / low 2 cycles -> never reaches RUN; STABLE<->WAIT_LOCK bouncing; no retry consumed while bouncing.
- Lock loss in RUN: pll_locked drops -> sys_rst=1 and ready=0 within 3 edges; with PLL_SEQ_AUTO_RELOCK_EN, state=PLL_RST and pll_rst pulses 4 cycles; without it, state=WAIT_LOCK and pll_rst stays 0.
- relock_req in FAIL -> PLL_RST next edge, fail=0, retry_cnt=0; relock_req in WAIT_LOCK -> ignored, state unchanged.
- rst asserted mid-STABLE -> next edge: all outputs at reset values, state=PLL_RST.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with a bounded
// retry count, qualifies lock stability, then releases the system reset.
// Run-time lock loss drops the system reset again; relock_req restarts the
// sequence from RUN or FAIL.
// Optional build macro: PLL_SEQ_AUTO_RELOCK_EN -- when defined, lock loss in
// RUN re-pulses the PLL reset and clears retry_cnt; when undefined, the
// sequencer falls back to WAIT_LOCK with pll_rst low and retry_cnt held.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  state_t           cur;
  logic [CNT_W-1:0] cnt;
  logic             lock_meta;
  logic             locked_s;

  assign state = cur;

  // Two-flop synchronizer bringing pll_locked into the refclk domain.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge refclk) begin
    if (rst) begin
      cur       <= S_PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      case (cur)
        S_PLL_RST: begin
          if (cnt == RST_LAST) begin
            cur     <= S_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            cur <= S_STABLE;
            cnt <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt == RETRY_LIMIT) begin
              cur  <= S_FAIL;
              fail <= 1'b1;
            end else begin
              cur       <= S_PLL_RST;
              retry_cnt <= (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STABLE: begin
          if (!locked_s) begin
            cur <= S_WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            cur     <= S_RUN;
            cnt     <= '0;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          // relock_req is tested first so it wins over a simultaneous lock loss.
          if (relock_req) begin
            cur       <= S_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            retry_cnt <= '0;
          end else if (!locked_s) begin
            cnt     <= '0;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            cur       <= S_PLL_RST;
            pll_rst   <= 1'b1;
            retry_cnt <= '0;
`else
            cur <= S_WAIT_LOCK;
`endif
          end
        end

        S_FAIL: begin
          if (relock_req) begin
            cur       <= S_PLL_RST;
            cnt       <= '0;
            fail      <= 1'b0;
            retry_cnt <= '0;
          end
        end

        default: begin
          cur     <= S_PLL_RST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          ready   <= 1'b0;
          fail    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a phase/countdown reference model is compared
// against the DUT on every falling edge, and directed scenarios add literal
// expectations for pulse widths, latencies and retry behaviour.
module tb_pll_reset_sequencer;

  localparam int RST_C = 4;
  localparam int TO_C  = 32;
  localparam int ST_C  = 8;
  localparam int MAXR  = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int compared = 0;
  int mismatched = 0;

  pll_reset_sequencer #(
    .RST_CYCLES(RST_C),
    .LOCK_TIMEOUT(TO_C),
    .STABLE_CYCLES(ST_C),
    .MAX_RETRIES(MAXR),
    .CNT_W(16)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .state(state)
  );

  always #5 refclk = ~refclk;

  // Reference model: phase number (0 reset pulse, 1 lock wait, 2 stability,
  // 3 running, 4 failed) plus cycles remaining in the timed phase.
  int m_phase = 0;
  int m_left = 0;
  int m_retry = 0;
  bit m_hist1 = 0, m_hist2 = 0;
  bit m_valid = 0;

  always @(posedge refclk) begin
    bit seen;
    if (rst) begin
      m_phase = 0; m_left = RST_C; m_retry = 0;
      m_hist1 = 0; m_hist2 = 0; m_valid = 1;
    end else if (m_valid) begin
      seen = m_hist2;
      case (m_phase)
        0: begin
          m_left--;
          if (m_left == 0) begin m_phase = 1; m_left = TO_C; end
        end
        1: begin
          if (seen) begin m_phase = 2; m_left = ST_C; end
          else begin
            m_left--;
            if (m_left == 0) begin
              if (m_retry == MAXR) m_phase = 4;
              else begin m_retry++; m_phase = 0; m_left = RST_C; end
            end
          end
        end
        2: begin
          if (!seen) begin m_phase = 1; m_left = TO_C; end
          else begin
            m_left--;
            if (m_left == 0) m_phase = 3;
          end
        end
        3: begin
          if (relock_req) begin m_phase = 0; m_left = RST_C; m_retry = 0; end
          else if (!seen) begin
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            m_phase = 0; m_left = RST_C; m_retry = 0;
`else
            m_phase = 1; m_left = TO_C;
`endif
          end
        end
        default: begin
          if (relock_req) begin m_phase = 0; m_left = RST_C; m_retry = 0; end
        end
      endcase
      m_hist2 = m_hist1;
      m_hist1 = pll_locked;
    end
  end

  function automatic logic [8:0] model_vec();
    logic [8:0] v;
    v[8:6] = 3'(m_phase);
    v[5]   = (m_phase == 0) || (m_phase == 4);
    v[4]   = (m_phase != 3);
    v[3]   = (m_phase == 3);
    v[2]   = (m_phase == 4);
    v[1:0] = 2'(m_retry);
    return v;
  endfunction

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge refclk) begin
    logic [8:0] act, exp;
    if (m_valid) begin
      act = {state, pll_rst, sys_rst, ready, fail, retry_cnt[1:0]};
      exp = model_vec();
      compared++;
      if (act !== exp || retry_cnt[3:2] !== 2'b00) begin
        mismatched++;
        $display("FAIL model_cmp @%0t: got st=%0d prst=%b srst=%b rdy=%b fl=%b rc=%0d expected st=%0d prst=%b srst=%b rdy=%b fl=%b rc=%0d",
                 $time, state, pll_rst, sys_rst, ready, fail, retry_cnt,
                 exp[8:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  initial begin
    int n, cyc, prev, entries, last_entry, fail_at, bounces;
    int retry_at[4];
    bit seen_ready;

    // Power-up.
    rst = 1'b1;
    repeat (3) step();
    chk("reset_state", state, 0);
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_sys_rst", sys_rst, 1);
    rst = 1'b0;
    n = 0;
    while (pll_rst && n < 50) begin n++; step(); end
    chk("pll_rst_width", n, 4);
    repeat (6) step();
    pll_locked = 1'b1;
    n = 0;
    do begin step(); n++; end while (!ready && n < 60);
    chk("lock_to_ready", n, 11);
    chk("run_sys_rst", sys_rst, 0);
    chk("run_retry", retry_cnt, 0);

    // Never lock.
    pll_locked = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    prev = state; entries = 0; last_entry = 0; fail_at = -1; cyc = 0;
    for (int k = 0; k < 4; k++) retry_at[k] = -1;
    while (cyc < 300 && fail_at < 0) begin
      step(); cyc++;
      if (state == 3'd1 && prev != 1) begin
        entries++; last_entry = cyc;
        if (entries < 4) retry_at[entries] = retry_cnt;
      end
      if (state == 3'd4) fail_at = cyc;
      prev = state;
    end
    chk("fail_reached", state, 4);
    chk("wait_entries", entries, 3);
    chk("fail_after_wait", fail_at - last_entry, 32);
    chk("retry_at_2nd", retry_at[2], 1);
    chk("retry_at_3rd", retry_at[3], 2);
    chk("fail_flag", fail, 1);
    chk("fail_pll_rst", pll_rst, 1);

    // relock_req in FAIL, then in WAIT_LOCK.
    relock_req = 1'b1; step(); relock_req = 1'b0;
    chk("relock_state", state, 0);
    chk("relock_fail", fail, 0);
    chk("relock_retry", retry_cnt, 0);
    n = 0;
    while (state != 3'd1 && n < 20) begin step(); n++; end
    chk("reach_wait", state, 1);
    relock_req = 1'b1; step(); relock_req = 1'b0;
    chk("relock_ignored", state, 1);

    // Unstable lock: 5 high / 2 low.
    bounces = 0; seen_ready = 0; prev = state;
    for (int p = 0; p < 10; p++) begin
      pll_locked = 1'b1;
      for (int j = 0; j < 7; j++) begin
        if (j == 5) pll_locked = 1'b0;
        step();
        if (ready) seen_ready = 1;
        if (prev == 2 && state == 3'd1) bounces++;
        prev = state;
      end
    end
    chk("unstable_no_run", seen_ready, 0);
    chk("unstable_bounced", int'(bounces >= 8), 1);
    chk("unstable_retry", retry_cnt, 0);

    // Lock loss in RUN.
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 60) begin step(); n++; end
    chk("reach_run", ready, 1);
    pll_locked = 1'b0;
    n = 0;
    do begin step(); n++; end while (!(sys_rst && !ready) && n < 10);
    chk("loss_latency", n, 3);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
    chk("loss_state", state, 0);
    n = 0;
    while (pll_rst && n < 20) begin n++; step(); end
    chk("loss_pll_rst_width", n, 4);
`else
    chk("loss_state", state, 1);
    chk("loss_pll_rst", pll_rst, 0);
    repeat (5) step();
    chk("loss_pll_rst_held", pll_rst, 0);
`endif

    // rst mid-STABLE.
    pll_locked = 1'b1;
    n = 0;
    while (state != 3'd2 && n < 80) begin step(); n++; end
    chk("reach_stable", state, 2);
    repeat (3) step();
    rst = 1'b1; step();
    chk("midrst_state", state, 0);
    chk("midrst_outs", {pll_rst, sys_rst, ready, fail}, 4'b1100);
    chk("midrst_retry", retry_cnt, 0);
    rst = 1'b0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
